cv32e40p_tb_obi_mem_arbiter: RTL and testbench
==============================================

// Module: cv32e40p_tb_obi_mem_arbiter
// PURPOSE
//  Parametrised N-port OBI memory front-end for the core testbench subsystem. It replaces the fixed
//  instr/data pair into the RAM with round-robin arbitration of NUM_PORTS masters (core instr, core
//  data, DMA/debug stubs) onto one single-port synchronous SRAM. Adds programmable response latency
//  and optional pseudo-random grant stalls for protocol stress.
// PARAMETERS
//  NUM_PORTS     2            number of OBI masters, 1..8
//  ADDR_WIDTH    18           byte-address bits forwarded to SRAM
//  DATA_WIDTH    32           data width; BE width = DATA_WIDTH/8
//  RESP_LATENCY  1            cycles from grant to rvalid, 1..8
//  STALL_SEED    16'hACE1     LFSR reset seed (used only with stall feature)
// PORTS
//  clk_i          in   1                        clock
//  rst_i          in   1                        asynchronous reset, active-high
//  req_i          in   [NUM_PORTS]              OBI request per port
//  gnt_o          out  [NUM_PORTS]              OBI grant per port
//  addr_i         in   [NUM_PORTS][31:0]        byte address per port
//  we_i           in   [NUM_PORTS]              write enable per port
//  be_i           in   [NUM_PORTS][DW/8]        byte enables per port
//  wdata_i        in   [NUM_PORTS][DW]          write data per port
//  rvalid_o       out  [NUM_PORTS]              response valid per port
//  rdata_o        out  [NUM_PORTS][DW]          read data per port
//  mem_req_o      out  1                        SRAM access strobe
//  mem_addr_o     out  ADDR_WIDTH-2             SRAM word address
//  mem_we_o / mem_be_o / mem_wdata_o  out       SRAM write controls, from winner
//  mem_rdata_i    in   DW                       SRAM read data, valid 1 cycle after mem_req_o
// BEHAVIOUR
//  - Reset: rr_ptr=0, response pipe cleared, LFSR=STALL_SEED; all outputs 0 while rst_i high.
//  - Arbitration is combinational: winner = first port with req_i set, scanning from rr_ptr upward
//    with wrap. gnt_o[winner]=1 in the same cycle (0-cycle grant). At most one gnt per cycle.
//  - On grant: rr_ptr <= (winner==NUM_PORTS-1) ? 0 : winner+1. No grant -> rr_ptr holds.
//  - mem_* driven from winner; mem_addr_o=addr_i[w][ADDR_WIDTH-1:2]; mem_req_o=|gnt_o.
//  - Response pipe is RESP_LATENCY deep and carries {valid, port_id, we}. Read data is captured
//    at stage 1 (mem_rdata_i) and shifted with the tag. Exactly one rvalid_o pulse per grant.
//  - rdata_o[p] = captured data on a read; all-zero on a write (write still gets rvalid).
//  - rdata_o for ports without rvalid is 0. Per-port order is preserved; fixed latency, no reordering.
//  - Back-to-back grants every cycle are sustained; throughput is 1 access/cycle.
//  - Two requesters are served alternately; a continuously requesting port cannot starve another.
//  - req_i falling without gnt is tolerated; no state change occurs.
//  - Mid-operation reset drops in-flight responses; no rvalid_o after rst_i deasserts for them.
// CONFIGURATION
//  TB_OBI_STALL_EN defined: a 16-bit Fibonacci LFSR (taps 16,14,13,11) advances every cycle.
//    When lfsr[1:0]==2'b00, all grants are suppressed that cycle: no gnt_o, no mem_req_o, rr_ptr
//    holds. Stall cycles are deterministic from STALL_SEED.
//  Not defined: no LFSR; grant is never suppressed.
// STRUCTURE
//  Package cv32e40p_tb_obi_pkg: port_id_t = logic [$clog2(NUM_PORTS>1?NUM_PORTS:2)-1:0];
//    resp_tag_t struct {valid, port_id, we}; constant MAX_PORTS=8.
//  Sub-module cv32e40p_tb_rr_arbiter: NUM_PORTS req vector + enable -> one-hot gnt, winner id,
//    rr_ptr register. Response pipe and LFSR live in the top.
// TESTING
//  1 Reset: rst_i=1 with req_i=2'b11 -> gnt_o=0, rvalid_o=0, mem_req_o=0.
//  2 Single read: port0 addr 0x100, SRAM[0x40]=0xDEADBEEF, LAT=1 -> gnt same cycle, next cycle
//    rvalid_o[0]=1, rdata_o[0]=0xDEADBEEF.
//  3 Fairness: req_i=2'b11 for 6 cycles -> grants 0,1,0,1,0,1; rvalid sequence matches, delayed by LAT.
//  4 Latency: RESP_LATENCY=4, write at cycle 0 -> rvalid_o pulse at cycle 4 only, rdata_o=0.
//  5 Reset mid-flight: LAT=3, grant at t, rst_i pulse at t+1 -> no rvalid_o at t+3.
//  6 Stall (TB_OBI_STALL_EN, seed 16'hACE1) -> gnt_o low exactly on the LFSR-predicted cycles;
//    every request is eventually granted.

Source files
------------

// File: rtl/cv32e40p_tb_obi_pkg.sv
// ---------------------------------------------------------------------------
// cv32e40p_tb_obi_pkg
// Shared types for the testbench OBI memory arbiter.
//   port_id_t  : index of an OBI master. Sized for MAX_PORTS so one type
//                serves every NUM_PORTS configuration (1..8).
//   resp_tag_t : entry of the response pipe {valid, port_id, we}.
//   next_ptr() : round-robin pointer advance with wrap.
// ---------------------------------------------------------------------------
package cv32e40p_tb_obi_pkg;

  localparam int MAX_PORTS = 8;

  typedef logic [$clog2(MAX_PORTS)-1:0] port_id_t;

  typedef struct packed {
    logic     valid;
    port_id_t port_id;
    logic     we;
  } resp_tag_t;

  // The port after the winner becomes highest priority next time.
  function automatic port_id_t next_ptr(input port_id_t winner, input int num_ports);
    return (int'(winner) == num_ports - 1) ? '0 : winner + port_id_t'(1);
  endfunction

endpackage

// File: rtl/cv32e40p_tb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40p_tb_rr_arbiter
// Round-robin arbiter with a 0-cycle (combinational) grant.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   req_i        : request vector, one bit per master
//   en_i         : when low no grant is issued and the pointer holds
//   gnt_o        : one-hot grant
//   winner_o     : index of the granted master
//   valid_o      : a grant was issued this cycle
// The search starts at rr_ptr and wraps; after a grant the pointer moves to
// the port following the winner.
// ---------------------------------------------------------------------------
module cv32e40p_tb_rr_arbiter
  import cv32e40p_tb_obi_pkg::*;
#(
  parameter int NUM_PORTS = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_PORTS-1:0] req_i,
  input  logic                 en_i,
  output logic [NUM_PORTS-1:0] gnt_o,
  output port_id_t             winner_o,
  output logic                 valid_o
);

  port_id_t rr_ptr_q;

  // Two passes with constant indices: first the ports at or above the
  // pointer, then the wrapped-around ports below it.
  always_comb begin
    // NOTE: every output gets a default before any branch, so no latch can be inferred.
    gnt_o    = '0;
    winner_o = '0;
    valid_o  = 1'b0;
    if (en_i) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!valid_o && req_i[i] && (port_id_t'(i) >= rr_ptr_q)) begin
          valid_o  = 1'b1;
          gnt_o[i] = 1'b1;
          winner_o = port_id_t'(i);
        end
      end
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (!valid_o && req_i[i]) begin
          valid_o  = 1'b1;
          gnt_o[i] = 1'b1;
          winner_o = port_id_t'(i);
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
    end else if (valid_o) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      rr_ptr_q <= next_ptr(winner_o, NUM_PORTS);
    end
  end

endmodule

// File: rtl/cv32e40p_tb_obi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// cv32e40p_tb_obi_mem_arbiter
// N-port OBI front-end onto one single-port synchronous SRAM.
//   clk_i, rst_i       : clock, asynchronous active-high reset
//   req_i / gnt_o      : OBI request / 0-cycle grant per port
//   addr_i, we_i, be_i, wdata_i : OBI request payload per port
//   rvalid_o, rdata_o  : OBI response per port (rdata zero on writes and
//                        for ports without rvalid)
//   mem_req_o, mem_addr_o (word address), mem_we_o, mem_be_o, mem_wdata_o :
//                        SRAM controls driven from the granted port
//   mem_rdata_i        : SRAM read data, valid the cycle after mem_req_o
// Responses follow the grant by exactly RESP_LATENCY cycles, in grant order.
//
// Optional feature: define TB_OBI_STALL_EN to add a 16-bit Fibonacci LFSR
// (taps 16,14,13,11, seeded with STALL_SEED) that suppresses all grants on
// cycles where lfsr[1:0] == 2'b00.
// ---------------------------------------------------------------------------
module cv32e40p_tb_obi_mem_arbiter
  import cv32e40p_tb_obi_pkg::*;
#(
  parameter int          NUM_PORTS    = 2,
  parameter int          ADDR_WIDTH   = 18,
  parameter int          DATA_WIDTH   = 32,
  parameter int          RESP_LATENCY = 1,
  parameter logic [15:0] STALL_SEED   = 16'hACE1
) (
  input  logic                                   clk_i,
  input  logic                                   rst_i,
  input  logic [NUM_PORTS-1:0]                   req_i,
  output logic [NUM_PORTS-1:0]                   gnt_o,
  input  logic [NUM_PORTS-1:0][31:0]             addr_i,
  input  logic [NUM_PORTS-1:0]                   we_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH/8-1:0] be_i,
  input  logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_PORTS-1:0]                   rvalid_o,
  output logic [NUM_PORTS-1:0][DATA_WIDTH-1:0]   rdata_o,
  output logic                                   mem_req_o,
  output logic [ADDR_WIDTH-3:0]                  mem_addr_o,
  output logic                                   mem_we_o,
  output logic [DATA_WIDTH/8-1:0]                mem_be_o,
  output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
  input  logic [DATA_WIDTH-1:0]                  mem_rdata_i
);

  logic      arb_en;
  logic      arb_valid;
  port_id_t  winner;
  resp_tag_t tag_q [RESP_LATENCY];
  resp_tag_t out_tag;
  logic [DATA_WIDTH-1:0] resp_data;

  // Only the word-address bits reach the SRAM; the rest are ignored.
  logic unused_addr_bits;
  assign unused_addr_bits = ^addr_i;

  // ---------------------------------------------------------------- stalls
`ifdef TB_OBI_STALL_EN
  logic [15:0] lfsr_q;
  logic        stall;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= STALL_SEED;
    end else begin
      lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    end
  end

  assign stall  = (lfsr_q[1:0] == 2'b00);
  assign arb_en = !rst_i && !stall;
`else
  localparam logic [15:0] unused_stall_seed = STALL_SEED;
  // Gating with reset keeps gnt_o and mem_* low while rst_i is high.
  assign arb_en = !rst_i;
`endif

  // ----------------------------------------------------------- arbitration
  cv32e40p_tb_rr_arbiter #(
    .NUM_PORTS (NUM_PORTS)
  ) u_rr_arbiter (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .req_i    (req_i),
    .en_i     (arb_en),
    .gnt_o    (gnt_o),
    .winner_o (winner),
    .valid_o  (arb_valid)
  );

  assign mem_req_o = arb_valid;

  // One-hot select of the winner's request payload.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (gnt_o[i]) begin
        mem_addr_o  = addr_i[i][ADDR_WIDTH-1:2];
        mem_we_o    = we_i[i];
        mem_be_o    = be_i[i];
        mem_wdata_o = wdata_i[i];
      end
    end
  end

  // --------------------------------------------------------- response pipe
  // Stage 0 is loaded on the grant edge; the tag leaves after RESP_LATENCY
  // cycles. Reset flushes all in-flight responses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < RESP_LATENCY; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= {arb_valid, winner, mem_we_o};
      for (int i = 1; i < RESP_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign out_tag = tag_q[RESP_LATENCY-1];

  // SRAM data appears while the tag sits in stage 0; deeper pipes capture it
  // there and shift it alongside the tag.
  generate
    if (RESP_LATENCY == 1) begin : g_data_direct
      assign resp_data = mem_rdata_i;
    end else begin : g_data_pipe
      logic [DATA_WIDTH-1:0] data_q [1:RESP_LATENCY-1];

      // NOTE: the data pipe has no reset; it is only observed when the reset tag says valid.
      always_ff @(posedge clk_i) begin
        data_q[1] <= mem_rdata_i;
        for (int i = 2; i < RESP_LATENCY; i++) data_q[i] <= data_q[i-1];
      end

      assign resp_data = data_q[RESP_LATENCY-1];
    end
  endgenerate

  always_comb begin
    rvalid_o = '0;
    rdata_o  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (out_tag.valid && (out_tag.port_id == port_id_t'(p))) begin
        rvalid_o[p] = 1'b1;
        if (!out_tag.we) rdata_o[p] = resp_data;
      end
    end
  end

endmodule

// File: tb/tb_cv32e40p_tb_obi_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_cv32e40p_tb_obi_mem_arbiter
// Three arbiters (RESP_LATENCY 1, 3, 4) share one set of OBI inputs, each
// with its own SRAM model. Directed steps give the expected grant and
// response data; responses are queued per instance with their due cycle and
// a per-instance monitor compares rvalid_o/rdata_o every cycle.
// ---------------------------------------------------------------------------
module tb_cv32e40p_tb_obi_mem_arbiter;

  localparam int NI = 3;

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [1:0]       req = '0;
  logic [1:0][31:0] addr = '0;
  logic [1:0]       we = '0;
  logic [1:0][3:0]  be = '0;
  logic [1:0][31:0] wdata = '0;

  logic [1:0]       gnt     [NI];
  logic [1:0]       rvalid  [NI];
  logic [1:0][31:0] rdata   [NI];
  logic             mem_req [NI];
  logic [15:0]      mem_addr[NI];

  exp_t sb_q [NI][$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int lat_of(input int g);
    return (g == 0) ? 1 : (g == 1) ? 3 : 4;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ------------------------------------------------------------ instances
  for (genvar g = 0; g < NI; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : (g == 1) ? 3 : 4;

    logic        m_we;
    logic [3:0]  m_be;
    logic [31:0] m_wdata;
    logic [31:0] m_rdata;
    logic [31:0] sram [256];

    cv32e40p_tb_obi_mem_arbiter #(
      .NUM_PORTS    (2),
      .ADDR_WIDTH   (18),
      .DATA_WIDTH   (32),
      .RESP_LATENCY (LAT),
      .STALL_SEED   (16'hACE1)
    ) u_dut (
      .clk_i       (clk),
      .rst_i       (rst),
      .req_i       (req),
      .gnt_o       (gnt[g]),
      .addr_i      (addr),
      .we_i        (we),
      .be_i        (be),
      .wdata_i     (wdata),
      .rvalid_o    (rvalid[g]),
      .rdata_o     (rdata[g]),
      .mem_req_o   (mem_req[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_we_o    (m_we),
      .mem_be_o    (m_be),
      .mem_wdata_o (m_wdata),
      .mem_rdata_i (m_rdata)
    );

    initial begin
      m_rdata = '0;
      for (int k = 0; k < 256; k++) sram[k] = '0;
      sram[8'h40] = 32'hDEADBEEF;  // byte address 0x100
      sram[8'h41] = 32'hCAFEF00D;  // byte address 0x104
      sram[8'h42] = 32'h0BADC0DE;  // byte address 0x108
    end

    always @(posedge clk) begin
      if (mem_req[g]) begin
        if (m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) sram[mem_addr[g][7:0]][8*b +: 8] <= m_wdata[8*b +: 8];
        end else begin
          m_rdata <= sram[mem_addr[g][7:0]];
        end
      end
    end

    // Monitor: the queue head due this cycle defines the expected response.
    always @(negedge clk) begin : monitor
      logic [1:0]  ev;
      logic [63:0] ed;
      exp_t        e;
      ev = '0;
      ed = '0;
      if (sb_q[g].size() != 0 && sb_q[g][0].due == cyc) begin
        e = sb_q[g].pop_front();
        ev[e.port] = 1'b1;
        ed[e.port*32 +: 32] = e.data;
      end
      check($sformatf("rvalid_lat%0d", LAT), 64'(rvalid[g]), 64'(ev));
      check($sformatf("rdata_lat%0d", LAT), 64'(rdata[g]), ed);
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    for (int i = 0; i < NI; i++) sb_q[i].delete();
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic idle(input int n);
    req = '0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One request cycle: drive, check the combinational grant, queue the response.
  task automatic step(input logic [1:0] r, input logic [1:0] eg, input logic [31:0] exp_data);
    int p;
    req = r;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("gnt_inst%0d", g), 64'(gnt[g]), 64'(eg));
      check($sformatf("mem_req_inst%0d", g), 64'(mem_req[g]), 64'(|eg));
    end
    if (eg != 2'b00) begin
      p = eg[1] ? 1 : 0;
      check("mem_addr", 64'(mem_addr[0]), 64'(addr[p][17:2]));
      for (int g = 0; g < NI; g++) sb_q[g].push_back('{p, exp_data, cyc + lat_of(g)});
    end
    @(posedge clk);
    #1;
  endtask

`ifdef TB_OBI_STALL_EN
  logic [15:0] lfsr_m;
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], ^(lfsr_m & 16'hB400)};
  end
`endif

  initial begin
    // Reset with both ports requesting: nothing may be granted.
    rst = 1'b1;
    req = 2'b11;
    @(negedge clk);
    for (int g = 0; g < NI; g++) begin
      check($sformatf("reset_gnt_inst%0d", g), 64'(gnt[g]), 64'd0);
      check($sformatf("reset_mem_req_inst%0d", g), 64'(mem_req[g]), 64'd0);
    end
    @(posedge clk);
    #1;
    do_reset();

`ifndef TB_OBI_STALL_EN
    // Single read.
    addr[0] = 32'h100;
    step(2'b01, 2'b01, 32'hDEADBEEF);
    idle(6);

    // Fairness with both ports requesting continuously.
    do_reset();
    addr[1] = 32'h104;
    for (int i = 0; i < 6; i++)
      step(2'b11, (i % 2 == 0) ? 2'b01 : 2'b10, (i % 2 == 0) ? 32'hDEADBEEF : 32'hCAFEF00D);
    idle(6);

    // Write (response with zero data), then read back the merged bytes;
    // the second grant wraps the pointer past port 0.
    addr[1] = 32'h200; we[1] = 1'b1; wdata[1] = 32'h12345678; be[1] = 4'b0101;
    step(2'b10, 2'b10, 32'h0);
    we[1] = 1'b0;
    step(2'b10, 2'b10, 32'h00340078);
    idle(6);

    // Pointer holds over idle cycles.
    step(2'b01, 2'b01, 32'hDEADBEEF);
    idle(2);
    step(2'b11, 2'b10, 32'h00340078);
    step(2'b11, 2'b01, 32'hDEADBEEF);
    idle(6);

    // Reset one cycle after a grant: the response must never appear.
    do_reset();
    addr[0] = 32'h108;
    step(2'b01, 2'b01, 32'h0BADC0DE);
    do_reset();
    idle(6);
`else
    // Grants are withheld exactly on LFSR-predicted cycles.
    begin
      int grants = 0;
      addr[0] = 32'h100;
      for (int c = 0; c < 200 && grants < 10; c++) begin
        logic [1:0] eg;
        eg = (lfsr_m[1:0] == 2'b00) ? 2'b00 : 2'b01;
        step(2'b01, eg, 32'hDEADBEEF);
        if (eg != 2'b00) grants++;
      end
      check("stall_grant_count", 64'(grants), 64'd10);
      idle(6);
    end
`endif

    for (int g = 0; g < NI; g++)
      check($sformatf("pending_inst%0d", g), 64'(sb_q[g].size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
